// File: rtl/alu_ctrl_pkg.sv
// Shared decode constants, FSM state and decoded-instruction struct for the ALU issue controller.
// Pure declarations, no logic.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_SEL_ROLV = 5'b00000;
  localparam logic [4:0] ALU_SEL_RORV = 5'b00001;
  localparam logic [4:0] ALU_SEL_NOT  = 5'b00010;
  localparam logic [4:0] ALU_SEL_NORI = 5'b00111;
  localparam logic [4:0] ALU_SEL_BLEU = 5'b01000;
  localparam logic [4:0] ALU_SEL_ADD  = 5'b10000;
  localparam logic [4:0] ALU_SEL_NOR  = 5'b10011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_NORI  = 6'h0E;
  localparam logic [5:0] OP_BLEU  = 6'h1C;

  localparam logic [5:0] FUNCT_ROLV = 6'h04;
  localparam logic [5:0] FUNCT_RORV = 6'h06;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_NOT  = 6'h28;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  typedef enum logic       {A_RS, A_RT} a_src_t;
  typedef enum logic [1:0] {B_RT, B_RS, B_ZERO, B_IMM} b_src_t;
  typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_RT} dest_kind_t;

  typedef struct packed {
    logic [4:0] sel;
    b_src_t     b_src;
    a_src_t     a_src;
    dest_kind_t dest_kind;
    logic       is_branch;
    logic       legal;
  } decode_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder: instr -> ALU selector, operand sources, destination kind.
// All-zero instr decodes as a legal NOP; anything unlisted comes back with legal=0.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    dec = '{sel: ALU_SEL_ROLV, b_src: B_ZERO, a_src: A_RS, dest_kind: DEST_NONE,
            is_branch: 1'b0, legal: 1'b0};
    if (instr == 32'h0) begin
      dec.legal = 1'b1;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FUNCT_ADD: begin
              dec.sel = ALU_SEL_ADD; dec.b_src = B_RT; dec.dest_kind = DEST_RD; dec.legal = 1'b1;
            end
            FUNCT_NOR: begin
              dec.sel = ALU_SEL_NOR; dec.b_src = B_RT; dec.dest_kind = DEST_RD; dec.legal = 1'b1;
            end
            FUNCT_NOT: begin
              dec.sel = ALU_SEL_NOT; dec.b_src = B_ZERO; dec.dest_kind = DEST_RD; dec.legal = 1'b1;
            end
            // rotates take the value from rt and the amount from rs
            FUNCT_ROLV: begin
              dec.sel = ALU_SEL_ROLV; dec.a_src = A_RT; dec.b_src = B_RS;
              dec.dest_kind = DEST_RD; dec.legal = 1'b1;
            end
            FUNCT_RORV: begin
              dec.sel = ALU_SEL_RORV; dec.a_src = A_RT; dec.b_src = B_RS;
              dec.dest_kind = DEST_RD; dec.legal = 1'b1;
            end
            default: ;
          endcase
        end
        OP_NORI: begin
          dec.sel = ALU_SEL_NORI; dec.b_src = B_IMM; dec.dest_kind = DEST_RT; dec.legal = 1'b1;
        end
        OP_BLEU: begin
          dec.sel = ALU_SEL_BLEU; dec.b_src = B_RT; dec.is_branch = 1'b1; dec.legal = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle ALU issue controller: accept in IDLE, read RF, drive ALU, strobe writeback/branch 3 cycles later.
// instr_ready only in IDLE (next accept at cycle 4); ALU_ILLEGAL_TRAP_EN makes bad opcodes pulse illegal_op and lock.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  output logic [RADDR-1:0] rf_raddr1,
  output logic [RADDR-1:0] rf_raddr2,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  output logic [4:0]       alu_sel,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_o,
  output logic             rf_we,
  output logic [RADDR-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             br_valid,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target,
  output logic             illegal_op
);

  state_t            state, state_nxt;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   pc_q;
  decode_t           dec;
  logic              locked;
  logic              accept;
  logic [XLEN-1:0]   a_mux, b_mux;
  logic [RADDR-1:0]  waddr_mux;
  logic              do_write;
  logic [XLEN-1:0]   br_off;

  alu_op_decode u_decode (
    .instr (instr_q),
    .dec   (dec)
  );

  assign rf_raddr1 = instr_q[25:21];
  assign rf_raddr2 = instr_q[20:16];

  // ready drops combinationally with reset so the reset cycle never handshakes
  assign instr_ready = (state == IDLE) && !locked && !reset;
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_mux = (dec.a_src == A_RT) ? rf_rdata2 : rf_rdata1;
    case (dec.b_src)
      B_RT:    b_mux = rf_rdata2;
      B_RS:    b_mux = rf_rdata1;
      B_IMM:   b_mux = {{(XLEN-16){1'b0}}, instr_q[15:0]};
      default: b_mux = '0;
    endcase
  end

  assign waddr_mux = (dest_is_rt(dec)) ? instr_q[20:16] : instr_q[15:11];
  assign do_write  = dec.legal && (dec.dest_kind != DEST_NONE) && (waddr_mux != '0);
  assign br_off    = {{(XLEN-18){instr_q[15]}}, instr_q[15:0], 2'b00};

  function automatic logic dest_is_rt(input decode_t d);
    return d.dest_kind == DEST_RT;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= '0;
      pc_q      <= '0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      br_valid  <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      rf_we    <= 1'b0;
      br_valid <= 1'b0;
      if (accept) begin
        instr_q <= instr;
        pc_q    <= pc;
      end
      if (state == READ) begin
        alu_sel <= dec.sel;
        alu_a   <= a_mux;
        alu_b   <= b_mux;
      end
      // strobes are registered here so they appear during WB
      if (state == EXEC) begin
        rf_wdata <= alu_o;
        if (do_write) begin
          rf_we    <= 1'b1;
          rf_waddr <= waddr_mux;
        end
        if (dec.legal && dec.is_branch) begin
          br_valid  <= 1'b1;
          br_taken  <= alu_o[0];
          br_target <= pc_q + XLEN'(4) + br_off;
        end
      end
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_op <= 1'b0;
      locked     <= 1'b0;
    end else begin
      illegal_op <= (state == EXEC) && !dec.legal;
      if ((state == EXEC) && !dec.legal) locked <= 1'b1;
    end
  end
`else
  assign illegal_op = 1'b0;
  assign locked     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed + randomized bench for alu_issue_ctrl with a behavioural ALU, register file and reference model.
module tb_alu_issue_ctrl;

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int K_NONE = 0, K_WR = 1, K_BR = 2, K_ILL = 3;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [4:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_o;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        br_valid, br_taken;
  logic [31:0] br_target;
  logic        illegal_op;

  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    bit          chk_ops;
    logic [4:0]  sel;
    logic [31:0] a, b;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  alu_issue_ctrl #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_sel(alu_sel), .alu_a(alu_a),
    .alu_b(alu_b), .alu_o(alu_o), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // behavioural ALU seen by the DUT
  always_comb begin
    logic [63:0] t;
    t = 64'h0;
    alu_o = 32'hDEAD_BEEF;
    case (alu_sel)
      5'b10000: alu_o = alu_a + alu_b;
      5'b10011: alu_o = ~(alu_a | alu_b);
      5'b00111: alu_o = ~(alu_a | alu_b);
      5'b00010: alu_o = ~alu_a;
      5'b00000: begin t = {alu_a, alu_a} << alu_b[4:0]; alu_o = t[63:32]; end
      5'b00001: begin t = {alu_a, alu_a} >> alu_b[4:0]; alu_o = t[31:0]; end
      5'b01000: alu_o = {31'b0, alu_a <= alu_b};
      default: ;
    endcase
  end

  function automatic logic [31:0] rot(input logic [31:0] v, input int amt, input bit left);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < amt; i++) r = left ? {r[30:0], r[31]} : {r[0], r[31:1]};
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
    exp_t e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [31:0] vs, vt, zimm, simm;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    vs = rf[rs]; vt = rf[rt];
    zimm = {16'h0, ins[15:0]};
    simm = {{16{ins[15]}}, ins[15:0]};
    e = '{kind: K_NONE, chk_ops: 1'b0, sel: 5'h0, a: 32'h0, b: 32'h0, waddr: 5'h0,
          wdata: 32'h0, taken: 1'b0, target: 32'h0};
    if (ins == 32'h0) return e;
    e.kind = K_WR; e.chk_ops = 1'b1; e.waddr = rd;
    if (op == 6'h00 && fn == 6'h20) begin
      e.sel = 5'b10000; e.a = vs; e.b = vt; e.wdata = vs + vt;
    end else if (op == 6'h00 && fn == 6'h27) begin
      e.sel = 5'b10011; e.a = vs; e.b = vt; e.wdata = ~(vs | vt);
    end else if (op == 6'h00 && fn == 6'h28) begin
      e.sel = 5'b00010; e.a = vs; e.b = 32'h0; e.wdata = ~vs;
    end else if (op == 6'h00 && fn == 6'h04) begin
      e.sel = 5'b00000; e.a = vt; e.b = vs; e.wdata = rot(vt, int'(vs % 32), 1'b1);
    end else if (op == 6'h00 && fn == 6'h06) begin
      e.sel = 5'b00001; e.a = vt; e.b = vs; e.wdata = rot(vt, int'(vs % 32), 1'b0);
    end else if (op == 6'h0E) begin
      e.sel = 5'b00111; e.a = vs; e.b = zimm; e.wdata = ~(vs | zimm); e.waddr = rt;
    end else if (op == 6'h1C) begin
      e.kind = K_BR; e.sel = 5'b01000; e.a = vs; e.b = vt;
      e.taken = (vs <= vt); e.target = p + 32'd4 + simm * 32'd4;
    end else begin
      e.kind = K_ILL; e.chk_ops = 1'b0;
    end
    if (e.kind == K_WR && e.waddr == 5'd0) e.kind = K_NONE;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rf_we"}, {31'b0, rf_we}, 32'h0);
    check({tag, "_br_valid"}, {31'b0, br_valid}, 32'h0);
    check({tag, "_illegal"}, {31'b0, illegal_op}, 32'h0);
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 4.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] p, input bit hold);
    exp_t e;
    e = model(ins, p);
    instr_valid = 1'b1; instr = ins; pc = p;
    check("ready_c0", {31'b0, instr_ready}, 32'h1);
    @(negedge clk);
    if (!hold) begin instr_valid = 1'b0; instr = $urandom; pc = $urandom; end
    check("ready_c1", {31'b0, instr_ready}, 32'h0);
    check_quiet("c1");
    @(negedge clk);
    check("ready_c2", {31'b0, instr_ready}, 32'h0);
    check_quiet("c2");
    if (e.chk_ops) begin
      check("alu_sel", {27'b0, alu_sel}, {27'b0, e.sel});
      check("alu_a", alu_a, e.a);
      check("alu_b", alu_b, e.b);
    end
    @(negedge clk);
    check("ready_c3", {31'b0, instr_ready}, 32'h0);
    check("rf_we", {31'b0, rf_we}, {31'b0, e.kind == K_WR});
    if (e.kind == K_WR) begin
      check("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.waddr});
      check("rf_wdata", rf_wdata, e.wdata);
    end
    check("br_valid", {31'b0, br_valid}, {31'b0, e.kind == K_BR});
    if (e.kind == K_BR) begin
      check("br_taken", {31'b0, br_taken}, {31'b0, e.taken});
      check("br_target", br_target, e.target);
    end
    check("illegal_op", {31'b0, illegal_op}, {31'b0, TRAP && e.kind == K_ILL});
    @(negedge clk);
    check_quiet("c4");
    check("ready_c4", {31'b0, instr_ready}, {31'b0, !(TRAP && e.kind == K_ILL)});
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("ready_idle", {31'b0, instr_ready}, 32'h1);
      check_quiet("idle");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, {27'b0, alu_sel}, 32'h0);
    check({tag, "_a"}, alu_a, 32'h0);
    check({tag, "_b"}, alu_b, 32'h0);
    check({tag, "_waddr"}, {27'b0, rf_waddr}, 32'h0);
    check({tag, "_wdata"}, rf_wdata, 32'h0);
    check({tag, "_taken"}, {31'b0, br_taken}, 32'h0);
    check({tag, "_target"}, br_target, 32'h0);
    check({tag, "_ready"}, {31'b0, instr_ready}, 32'h0);
    check_quiet(tag);
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'($urandom_range(0, 31)), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn_tab [5];
    logic [5:0] op;
    int k;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h27; fn_tab[2] = 6'h28; fn_tab[3] = 6'h04; fn_tab[4] = 6'h06;
    k = $urandom_range(0, 9);
    if (TRAP && k == 8) k = 7;
    case (k)
      0, 1, 2, 3, 4: return rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), fn_tab[k]);
      5: return itype(6'h0E, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
      6: return itype(6'h1C, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
      7: return 32'h0;
      8: begin
        op = 6'($urandom_range(1, 63));
        if (op == 6'h0E || op == 6'h1C) op = 6'h3F;
        return {op, 26'($urandom)};
      end
      default: return rtype($urandom_range(0, 31), $urandom_range(0, 31), 0, 6'h20);
    endcase
  endfunction

  task automatic rand_rf();
    for (int i = 0; i < 32; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    rf[0] = 32'h0;
  endtask

  initial begin
    rand_rf();
    reset = 1'b1; instr_valid = 1'b0; instr = 32'h0; pc = 32'h0;
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'b0, instr_ready}, 32'h1);
    @(negedge clk);

    rf[1] = 32'd5; rf[2] = 32'd7;
    run_instr(rtype(1, 2, 3, 6'h20), 32'h0, 1'b0);
    check("add_lit", rf_wdata, 32'd12);

    rf[4] = 32'h1234_0000;
    run_instr(itype(6'h0E, 4, 9, 16'hFFFF), 32'h40, 1'b0);
    idle(1);

    rf[3] = 32'd5; rf[8] = 32'd9;
    run_instr(itype(6'h1C, 3, 8, 16'd2), 32'd100, 1'b0);
    check("bleu_target_lit", br_target, 32'd112);
    rf[3] = 32'd10;
    run_instr(itype(6'h1C, 3, 8, 16'd2), 32'd100, 1'b0);
    rf[3] = 32'd9;
    run_instr(itype(6'h1C, 3, 8, 16'hFFFE), 32'd100, 1'b0);
    rf[3] = 32'hFFFF_FFFF; rf[8] = 32'd1;
    run_instr(itype(6'h1C, 3, 8, 16'h0010), 32'hFFFF_FFF0, 1'b0);

    run_instr(rtype(1, 2, 0, 6'h20), 32'h8, 1'b0);
    run_instr(32'h0, 32'hC, 1'b0);
    rf[5] = 32'h8000_0001; rf[6] = 32'd33;
    run_instr(rtype(6, 5, 7, 6'h04), 32'h10, 1'b0);
    run_instr(rtype(6, 5, 7, 6'h06), 32'h14, 1'b0);
    run_instr(rtype(5, 6, 10, 6'h28), 32'h18, 1'b1);
    run_instr(rtype(5, 6, 11, 6'h27), 32'h1C, 1'b0);

    // reset while the add sits in EXEC: no strobe, everything cleared
    rf[3] = 32'd1; rf[8] = 32'd2;
    run_instr(itype(6'h1C, 3, 8, 16'd4), 32'h200, 1'b0);
    instr_valid = 1'b1; instr = rtype(1, 2, 3, 6'h20); pc = 32'h300;
    check("ready_pre_rst", {31'b0, instr_ready}, 32'h1);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    #1;
    check("ready_post_mid_reset", {31'b0, instr_ready}, 32'h1);
    @(negedge clk);
    check_quiet("post_mid_reset");

    run_instr({6'h3F, 26'h123_4567}, 32'h400, 1'b0);
`ifdef ALU_ILLEGAL_TRAP_EN
    instr_valid = 1'b1; instr = rtype(1, 2, 3, 6'h20);
    repeat (3) begin
      @(negedge clk);
      check("locked_ready", {31'b0, instr_ready}, 32'h0);
      check_quiet("locked");
    end
    reset = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("unlock_ready", {31'b0, instr_ready}, 32'h1);
`else
    idle(1);
`endif

    for (int n = 0; n < 200; n++) begin
      bit hold;
      if (n % 25 == 0) rand_rf();
      hold = ($urandom_range(0, 4) == 0);
      run_instr(rand_instr(), $urandom, hold);
      if (!hold) idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
